phy_lane_arbiter: RTL and testbench

Round-robin burst arbiter that shares one 8-bit phy input lane (data_in_N/valid_in_N of phy) among four upstream requesters.
- Each requester presents byte+valid and is served in bounded bursts.
- The winner's bytes are registered onto the lane with one cycle of latency.
- Sits between the source logic and phy; runs in the clk_f domain.

---
 rtl/phy_lane_arbiter_pkg.sv | 13 +
 rtl/phy_lane_arbiter_if.sv | 45 ++++
 rtl/phy_lane_arbiter_rr_pick.sv | 25 ++
 rtl/phy_lane_arbiter.sv | 124 ++++++++++++
 tb/tb_phy_lane_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/phy_lane_arbiter_pkg.sv
// Shared constants and types for the phy lane arbiter.
// Optional grant statistics are enabled with the ARB_STATS_EN macro.
package phy_arb_pkg;
  localparam int NUM_REQ       = 4;
  localparam int IDX_W         = 2;
  localparam int DEF_BURST_MAX = 4;

  // FSM encoding: IDLE waits for a request, BURST owns the lane.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  typedef logic [IDX_W-1:0] req_idx_t;
endpackage

// File: rtl/phy_lane_arbiter_if.sv
// Requester/lane bundle between source logic (master) and the arbiter (slave).
// Handshake: a beat moves on a rising clk_f edge where valid_in_N & ready_N;
// valid_in_N is held until accepted, ready_N never looks at valid_in_N.
// grant_cnt_N signals exist only when ARB_STATS_EN is defined.
interface phy_lane_arbiter_if #(parameter int CNT_W = 16);
  logic [7:0] data_in_0, data_in_1, data_in_2, data_in_3;
  logic       valid_in_0, valid_in_1, valid_in_2, valid_in_3;
  logic       ready_0, ready_1, ready_2, ready_3;
  logic       pause;
  logic [7:0] data_out;
  logic       valid_out;
  logic [1:0] grant_id;
  logic       active;
`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3;

  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3, pause,
    input  ready_0, ready_1, ready_2, ready_3,
    input  data_out, valid_out, grant_id, active,
    input  grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3
  );
  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3, pause,
    output ready_0, ready_1, ready_2, ready_3,
    output data_out, valid_out, grant_id, active,
    output grant_cnt_0, grant_cnt_1, grant_cnt_2, grant_cnt_3
  );
`else
  modport master (
    output data_in_0, data_in_1, data_in_2, data_in_3,
    output valid_in_0, valid_in_1, valid_in_2, valid_in_3, pause,
    input  ready_0, ready_1, ready_2, ready_3,
    input  data_out, valid_out, grant_id, active
  );
  modport slave (
    input  data_in_0, data_in_1, data_in_2, data_in_3,
    input  valid_in_0, valid_in_1, valid_in_2, valid_in_3, pause,
    output ready_0, ready_1, ready_2, ready_3,
    output data_out, valid_out, grant_id, active
  );
`endif
endinterface

// File: rtl/phy_lane_arbiter_rr_pick.sv
// Rotate-priority encoder: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick
  import phy_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  req_idx_t           ptr,
  output req_idx_t           idx,
  output logic               any
);
  req_idx_t cand;

  // Scan from the lowest priority upward so the highest-priority hit lands last.
  always_comb begin
    idx  = ptr;
    any  = 1'b0;
    cand = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ptr + req_idx_t'(k);
      if (req[cand]) begin
        idx = cand;
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/phy_lane_arbiter.sv
// Round-robin burst arbiter sharing one 8-bit phy lane among four requesters.
// Define ARB_STATS_EN to add saturating per-requester accepted-beat counters.
module phy_lane_arbiter
  import phy_arb_pkg::*;
#(
  parameter int BURST_MAX = DEF_BURST_MAX,
  parameter int CNT_W     = 16
) (
  input  logic                clk_f,
  input  logic                reset_L,
  phy_lane_arbiter_if.slave   bus
);
  logic [0:0] state_q, state_d;
  req_idx_t   grant_q, grant_d;
  req_idx_t   ptr_q, ptr_d;
  logic [3:0] beat_q, beat_d;
  logic [7:0] data_q, data_d;
  logic       valid_q, valid_d;

  logic [NUM_REQ-1:0] req;
  logic [7:0]         din [NUM_REQ];
  req_idx_t           pick_ptr, pick_idx;
  logic               pick_any;
  logic               owner_valid, xfer, last_beat;

  assign req    = {bus.valid_in_3, bus.valid_in_2, bus.valid_in_1, bus.valid_in_0};
  assign din[0] = bus.data_in_0;
  assign din[1] = bus.data_in_1;
  assign din[2] = bus.data_in_2;
  assign din[3] = bus.data_in_3;

  // In BURST the only pick ever used is the handover, so scan from owner+1.
  assign pick_ptr    = (state_q == BURST) ? grant_q + 2'd1 : ptr_q;
  assign owner_valid = req[grant_q];
  assign xfer        = (state_q == BURST) && !bus.pause && owner_valid;
  assign last_beat   = (beat_q == 4'(BURST_MAX - 1));

  rr_pick u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Next-state: grant, burst counting, release with same-cycle re-pick.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (!bus.pause) begin
      if (state_q == IDLE) begin
        if (pick_any) begin
          state_d = BURST;
          grant_d = pick_idx;
          beat_d  = 4'd0;
        end
      end else begin
        if (xfer) begin
          data_d  = din[grant_q];
          valid_d = 1'b1;
          beat_d  = beat_q + 4'd1;
        end
        if (!owner_valid || last_beat) begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            grant_d = pick_idx;
            beat_d  = 4'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
    end
  end

  // State and lane registers.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign bus.data_out  = data_q;
  assign bus.valid_out = valid_q;
  assign bus.grant_id  = grant_q;
  assign bus.active    = (state_q == BURST);
  assign bus.ready_0   = (state_q == BURST) && (grant_q == 2'd0) && !bus.pause;
  assign bus.ready_1   = (state_q == BURST) && (grant_q == 2'd1) && !bus.pause;
  assign bus.ready_2   = (state_q == BURST) && (grant_q == 2'd2) && !bus.pause;
  assign bus.ready_3   = (state_q == BURST) && (grant_q == 2'd3) && !bus.pause;

`ifdef ARB_STATS_EN
  logic [CNT_W-1:0] gcnt_q [NUM_REQ];

  // Saturating accepted-beat counter for the current owner.
  always_ff @(posedge clk_f or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < NUM_REQ; i++) gcnt_q[i] <= '0;
    end else if (xfer && (gcnt_q[grant_q] != {CNT_W{1'b1}})) begin
      gcnt_q[grant_q] <= gcnt_q[grant_q] + 1'b1;
    end
  end

  assign bus.grant_cnt_0 = gcnt_q[0];
  assign bus.grant_cnt_1 = gcnt_q[1];
  assign bus.grant_cnt_2 = gcnt_q[2];
  assign bus.grant_cnt_3 = gcnt_q[3];
`endif
endmodule

// File: tb/tb_phy_lane_arbiter.sv
// Testbench for phy_lane_arbiter: reference model plus byte scoreboard and
// directed checks for rotation, handover, pause and asynchronous reset.
module tb_phy_lane_arbiter;
  import phy_arb_pkg::*;

  localparam int BMAX = 4;
`ifdef ARB_STATS_EN
  localparam int CNT_W = 4;
`else
  localparam int CNT_W = 16;
`endif

  // ---------------- clock / reset ----------------
  logic clk_f = 1'b0;
  logic reset_L = 1'b0;
  always #5 clk_f = ~clk_f;

  phy_lane_arbiter_if #(.CNT_W(CNT_W)) bus ();
  phy_lane_arbiter #(.BURST_MAX(BMAX), .CNT_W(CNT_W)) dut (
    .clk_f   (clk_f),
    .reset_L (reset_L),
    .bus     (bus)
  );

  logic [7:0] din [4];
  logic [3:0] vin = 4'b0;
  logic       pause_r = 1'b0;
  logic [3:0] rdy;

  assign bus.data_in_0  = din[0];
  assign bus.data_in_1  = din[1];
  assign bus.data_in_2  = din[2];
  assign bus.data_in_3  = din[3];
  assign bus.valid_in_0 = vin[0];
  assign bus.valid_in_1 = vin[1];
  assign bus.valid_in_2 = vin[2];
  assign bus.valid_in_3 = vin[3];
  assign bus.pause      = pause_r;
  assign rdy = {bus.ready_3, bus.ready_2, bus.ready_1, bus.ready_0};

  // ---------------- model and scoreboard ----------------
  int         n_checks = 0;
  int         n_fail   = 0;
  int         m_state, m_grant, m_ptr, m_beat;
  logic       m_vexp;
  logic [7:0] m_last;
  int         m_gcnt [4];
  logic [7:0] exp_q [$];
  logic [7:0] base [4];
  int         cnt [4];
  int         obs_log [$];
  int         vout_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] v, input int p);
    for (int k = 0; k < 4; k++) begin
      if (v[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_state = 0; m_grant = 0; m_ptr = 0; m_beat = 0;
    m_vexp = 1'b0; m_last = 8'h00;
    for (int r = 0; r < 4; r++) begin
      m_gcnt[r] = 0;
      cnt[r] = 0;
    end
    exp_q.delete();
    obs_log.delete();
    vout_cnt = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_data_out"}, 32'(bus.data_out), 32'h0);
    check_eq({tag, "_valid_out"}, 32'(bus.valid_out), 32'h0);
    check_eq({tag, "_grant_id"}, 32'(bus.grant_id), 32'h0);
    check_eq({tag, "_active"}, 32'(bus.active), 32'h0);
    check_eq({tag, "_ready"}, 32'(rdy), 32'h0);
`ifdef ARB_STATS_EN
    check_eq({tag, "_gcnt0"}, 32'(bus.grant_cnt_0), 32'h0);
    check_eq({tag, "_gcnt3"}, 32'(bus.grant_cnt_3), 32'h0);
`endif
  endtask

  // Synchronous-looking reset pulse aligned to the falling edge.
  task automatic apply_reset();
    reset_L = 1'b0;
    vin = 4'b0;
    pause_r = 1'b0;
    @(negedge clk_f);
    @(negedge clk_f);
    check_idle_outputs("reset");
    model_reset();
    reset_L = 1'b1;
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called at a falling edge with vin/pause already set; returns at the next one.
  task automatic tick();
    logic [3:0] er;
    logic       xfer;
    int         np;
    for (int r = 0; r < 4; r++) din[r] = base[r] + 8'(cnt[r]);
    #1;
    er = (m_state == 1 && !pause_r) ? 4'(1 << m_grant) : 4'b0;
    check_eq("ready", 32'(rdy), 32'(er));
    check_eq("active", 32'(bus.active), 32'(m_state));
    if (m_state == 1) check_eq("grant_id", 32'(bus.grant_id), 32'(m_grant));
    for (int r = 0; r < 4; r++) if (rdy[r] && vin[r]) obs_log.push_back(r);

    xfer = (m_state == 1) && !pause_r && vin[m_grant];
    if (xfer) begin
      exp_q.push_back(din[m_grant]);
      if (m_gcnt[m_grant] < (1 << CNT_W) - 1) m_gcnt[m_grant]++;
      cnt[m_grant]++;
    end
    if (!pause_r) begin
      if (m_state == 0) begin
        np = pick(vin, m_ptr);
        if (np >= 0) begin
          m_state = 1; m_grant = np; m_beat = 0;
        end
      end else begin
        if (xfer) m_beat++;
        if (!vin[m_grant] || (xfer && m_beat == BMAX)) begin
          m_ptr = (m_grant + 1) % 4;
          np = pick(vin, m_ptr);
          if (np >= 0) begin
            m_grant = np; m_beat = 0;
          end else begin
            m_state = 0;
          end
        end
      end
    end
    m_vexp = xfer;

    @(posedge clk_f);
    @(negedge clk_f);
    check_eq("valid_out", 32'(bus.valid_out), 32'(m_vexp));
    if (bus.valid_out) begin
      vout_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        m_last = exp_q.pop_front();
        check_eq("data_out", 32'(bus.data_out), 32'(m_last));
      end
    end else begin
      check_eq("data_hold", 32'(bus.data_out), 32'(m_last));
    end
`ifdef ARB_STATS_EN
    check_eq("gcnt0", 32'(bus.grant_cnt_0), 32'(m_gcnt[0]));
    check_eq("gcnt1", 32'(bus.grant_cnt_1), 32'(m_gcnt[1]));
    check_eq("gcnt2", 32'(bus.grant_cnt_2), 32'(m_gcnt[2]));
    check_eq("gcnt3", 32'(bus.grant_cnt_3), 32'(m_gcnt[3]));
`endif
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n_other;
    int found;
    for (int r = 0; r < 4; r++) begin
      base[r] = 8'(r * 16);
      din[r] = 8'h00;
    end
    model_reset();
    @(negedge clk_f);
    apply_reset();

    // Single requester 1 streaming 0x10..0x1F: re-granted every 4 beats, no bubble.
    base[1] = 8'h10;
    vin = 4'b0010;
    tick();
    obs_log.delete(); vout_cnt = 0;
    repeat (16) tick();
    check_eq("single_beats", 32'(vout_cnt), 32'd16);
    check_eq("single_log_len", 32'(obs_log.size()), 32'd16);
    n_other = 0;
    foreach (obs_log[i]) if (obs_log[i] != 1) n_other++;
    check_eq("single_owner", 32'(n_other), 32'd0);
    check_eq("single_last_byte", 32'(bus.data_out), 32'h1F);

    // All four valid: 0,1,2,3 four beats each, 16 bytes in 16 cycles.
    apply_reset();
    base[0] = 8'hA0; base[1] = 8'hB0; base[2] = 8'hC0; base[3] = 8'hD0;
    vin = 4'b1111;
    tick();
    obs_log.delete(); vout_cnt = 0;
    repeat (16) tick();
    check_eq("rr_beats", 32'(vout_cnt), 32'd16);
    check_eq("rr_log_len", 32'(obs_log.size()), 32'd16);
    for (int i = 0; i < 16 && i < obs_log.size(); i++)
      check_eq("rr_order", 32'(obs_log[i]), 32'(i / 4));
    vin = 4'b0000;
    repeat (2) tick();

    // Requester 0 drops after 2 beats while 3 waits: same-cycle handover, 0 after 3.
    apply_reset();
    vin = 4'b1001;
    repeat (3) tick();
    vin = 4'b1000;
    tick();
    check_eq("drop_handover", 32'(bus.grant_id), 32'd3);
    vin = 4'b1001;
    repeat (5) tick();
    check_eq("drop_log_len", 32'(obs_log.size()), 32'd7);
    if (obs_log.size() == 7) begin
      check_eq("drop_log0", 32'(obs_log[1]), 32'd0);
      check_eq("drop_log2", 32'(obs_log[2]), 32'd3);
      check_eq("drop_log5", 32'(obs_log[5]), 32'd3);
      check_eq("drop_log6", 32'(obs_log[6]), 32'd0);
    end
    vin = 4'b0000;
    repeat (2) tick();

    // Pause 3 cycles at beat_cnt=2 of requester 2; then exactly 2 more beats.
    apply_reset();
    vin = 4'b0100;
    repeat (3) tick();
    vin = 4'b1100;
    pause_r = 1'b1;
    repeat (3) begin
      tick();
      check_eq("pause_no_valid", 32'(bus.valid_out), 32'd0);
    end
    pause_r = 1'b0;
    obs_log.delete();
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      tick();
      if (bus.grant_id == 2'd3) found = 1;
    end
    check_eq("pause_rotate_seen", 32'(found), 32'd1);
    n_other = 0;
    foreach (obs_log[i]) if (obs_log[i] == 2) n_other++;
    check_eq("pause_resume_beats", 32'(n_other), 32'd2);
    vin = 4'b0000;
    repeat (6) tick();

    // Asynchronous reset mid-burst of requester 2, then scan restarts at 0.
    apply_reset();
    base[2] = 8'h20;
    vin = 4'b0100;
    repeat (3) tick();
    #2;
    reset_L = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    model_reset();
    vin = 4'b0000;
    @(negedge clk_f);
    reset_L = 1'b1;
    vin = 4'b1010;
    tick();
    check_eq("post_reset_grant", 32'(bus.grant_id), 32'd1);
    vin = 4'b0000;
    repeat (2) tick();

    // Requester 3 streams 20 beats (counter saturation when stats are built in).
    apply_reset();
    vin = 4'b1000;
    repeat (21) tick();
    check_eq("stream3_beats", 32'(obs_log.size()), 32'd20);
`ifdef ARB_STATS_EN
    check_eq("stats_sat3", 32'(bus.grant_cnt_3), 32'd15);
    check_eq("stats_other0", 32'(bus.grant_cnt_0), 32'd0);
    check_eq("stats_other1", 32'(bus.grant_cnt_1), 32'd0);
    check_eq("stats_other2", 32'(bus.grant_cnt_2), 32'd0);
`endif
    vin = 4'b0000;
    tick();

    // Random requests, drops and pauses against the model.
    apply_reset();
    for (int r = 0; r < 4; r++) base[r] = 8'($urandom_range(0, 255));
    for (int n = 0; n < 400; n++) begin
      for (int r = 0; r < 4; r++) begin
        if (!vin[r] && $urandom_range(0, 3) == 0) vin[r] = 1'b1;
        else if (vin[r] && $urandom_range(0, 15) == 0) vin[r] = 1'b0;
      end
      pause_r = ($urandom_range(0, 7) == 0);
      tick();
    end
    vin = 4'b0000;
    pause_r = 1'b0;
    repeat (3) tick();
    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
